voice_mixer: RTL and testbench
==============================

VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameter DIV, default 48: clocks per output sample; legal range 5..4095.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  sample-rate counter enable; low freezes the counter.
REQ-005 voice0  input  8  unsigned voice sample, 0x80 = silence.
REQ-006 voice1  input  8  unsigned voice sample, 0x80 = silence.
REQ-007 voice2  input  8  unsigned voice sample, 0x80 = silence.
REQ-008 voice_en  input  3  per-voice mix enable; bit n gates voice n.
REQ-009 sample_out  output  8  mixed unsigned sample; held between updates.
REQ-010 sample_valid  output  1  one-cycle strobe marking a new sample_out.

Function
REQ-011 Counter cnt SHALL count 0..DIV-1 while en=1, wrap to 0, and assert internal tick in the cycle where cnt==DIV-1.
REQ-012 The FSM SHALL have states IDLE, ACC0, ACC1, ACC2 and EMIT.
- IDLE->ACC0 on tick.
- ACC0->ACC1->ACC2->EMIT unconditionally.
- EMIT->IDLE.
REQ-013 On the tick edge, voice0..2 and voice_en SHALL be latched and the 10-bit signed accumulator cleared.
- Later input changes SHALL NOT affect the sample in progress.
REQ-014 In ACCn, the accumulator SHALL add sign-extended (voice_n - 128) if latched voice_en[n]=1, else add 0.
REQ-015 On entering EMIT:
- sample_out = sat8(acc >>> 1) XOR 0x80, where sat8 clamps to -128..127.
- sample_valid SHALL be high for exactly the EMIT cycle.
REQ-016 sample_valid SHALL rise exactly 4 cycles after the tick cycle; back-to-back strobes SHALL be exactly DIV cycles apart while en=1.
REQ-017 If en falls mid-sample, the FSM SHALL still complete through EMIT; only the counter freezes.
REQ-018 If en is low, cnt SHALL hold its value and resume from it when en returns high.
REQ-019 With voice_en=000, the emitted sample SHALL be 0x80 on every strobe.

Reset
REQ-020 While rst=1:
- cnt=0, state=IDLE, accumulator=0.
- sample_out=0x80, sample_valid=0.
REQ-021 Reset asserted mid-sample SHALL abort the sample with no strobe; after release, the first tick SHALL occur DIV-1 en-cycles later.

Configuration
REQ-022 Macro MIXER_V3OFF_EN: when defined, an extra input v3off (1 bit) SHALL exist, and v3off=1 SHALL force voice2's contribution to 0 regardless of voice_en[2], latched at tick.
REQ-023 Without MIXER_V3OFF_EN, the v3off port SHALL be absent and voice2 SHALL be gated only by voice_en[2].

Structure
REQ-024 Shared package sid_mix_pkg SHALL hold:
- the FSM state enum;
- constant DIV_MIN=5;
- constant SILENCE=8'h80;
- accumulator width constant ACC_W=10.
REQ-025 The sample-rate divider SHALL be a sub-module named sample_tick (ports clk, rst, en, tick; parameter DIV); the mixer FSM and datapath SHALL stay in voice_mixer.
REQ-026 An elaboration-time check SHALL reject DIV < DIV_MIN.

Verification
REQ-027 voice0..2=0xFF, voice_en=111 -> sum 381, >>>1 = 190, saturates -> sample_out=0xFF, one strobe.
REQ-028 voice0..2=0x00, voice_en=111 -> -384 >>>1 = -192, saturates -> sample_out=0x00.
REQ-029 voice0=0xC0, voice1=0x00, voice2=0xFF, voice_en=001 -> sample_out=0xA0; voice inputs changed right after tick do not alter the result.
REQ-030 DIV=48, en=1 from reset release -> first sample_valid at cycle 51 (tick at cycle 47, counting from cycle 0 after release); strobes every 48 cycles; en=0 for 10 cycles stretches the next gap to 58 cycles.
REQ-031 rst pulsed during ACC1 -> no strobe; sample_out=0x80 immediately; normal cadence resumes from cnt=0.
REQ-032 MIXER_V3OFF_EN defined, voice2=0xFF, voice_en=100:
- v3off=1 -> sample_out=0x80;
- v3off=0 -> sample_out=0xBF.

Source files
------------

// File: rtl/sid_mix_pkg.sv
// Shared types and constants for the three-voice mixer: FSM states, sizing
// constants and the per-voice centring / output saturation helpers.
package sid_mix_pkg;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, EMIT} mix_state_e;

  localparam int          DIV_MIN    = 5;
  localparam int          DIV_MAX    = 4095;
  localparam int          NUM_VOICES = 3;
  localparam int          ACC_W      = 10;
  localparam logic [7:0]  SILENCE    = 8'h80;

  localparam logic signed [ACC_W-1:0] S8_MAX = 127;
  localparam logic signed [ACC_W-1:0] S8_MIN = -128;

  // Offset-binary sample to signed (v - 128), sign-extended to accumulator width.
  function automatic logic signed [ACC_W-1:0] centre(input logic [7:0] v);
    return {{(ACC_W-7){~v[7]}}, v[6:0]};
  endfunction

  // Halve, clamp to the signed 8-bit range, then back to offset binary.
  function automatic logic [7:0] emit_code(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] h;
    logic [7:0]              s;
    h = a >>> 1;
    if (h > S8_MAX)      s = 8'h7f;
    else if (h < S8_MIN) s = 8'h80;
    else                 s = h[7:0];
    return s ^ SILENCE;
  endfunction

endpackage

// File: rtl/sample_tick.sv
// Sample-rate divider: counts 0..DIV-1 while enabled, tick marks the last count.
module sample_tick
  import sid_mix_pkg::*;
#(
  parameter int DIV = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(DIV - 1));
  // Gated by en so a frozen counter sitting on DIV-1 cannot re-fire.
  assign tick   = en & at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (en)     cnt <= at_end ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/voice_mixer.sv
// Three-voice sequential mixer: latches voices at each sample tick, accumulates
// one voice per cycle, emits a saturated sample. Optional MIXER_V3OFF_EN adds v3off.
module voice_mixer
  import sid_mix_pkg::*;
#(
  parameter int DIV = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] voice0,
  input  logic [7:0] voice1,
  input  logic [7:0] voice2,
  input  logic [2:0] voice_en,
`ifdef MIXER_V3OFF_EN
  input  logic       v3off,
`endif
  output logic [7:0] sample_out,
  output logic       sample_valid
);

  if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_div_chk
    $error("voice_mixer: DIV out of range");
  end

  mix_state_e state, state_nxt;

  logic                                 tick;
  logic [NUM_VOICES-1:0][7:0]           voice_in;
  logic [NUM_VOICES-1:0]                gate;
  logic [NUM_VOICES-1:0][7:0]           lat_voice;
  logic [NUM_VOICES-1:0]                lat_en;
  logic signed [ACC_W-1:0]              acc, acc_nxt;
  logic signed [ACC_W-1:0]              lane_c [NUM_VOICES];

  sample_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign voice_in = {voice2, voice1, voice0};

`ifdef MIXER_V3OFF_EN
  assign gate = voice_en & {~v3off, 2'b11};
`else
  assign gate = voice_en;
`endif

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_lane
    assign lane_c[gi] = lat_en[gi] ? centre(lat_voice[gi]) : '0;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    unique case (state)
      IDLE: if (tick) begin
        state_nxt = ACC0;
        acc_nxt   = '0;
      end
      ACC0: begin acc_nxt = acc + lane_c[0]; state_nxt = ACC1; end
      ACC1: begin acc_nxt = acc + lane_c[1]; state_nxt = ACC2; end
      ACC2: begin acc_nxt = acc + lane_c[2]; state_nxt = EMIT; end
      EMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      lat_voice  <= {NUM_VOICES{SILENCE}};
      lat_en     <= '0;
      sample_out <= SILENCE;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      if (state == IDLE && tick) begin
        lat_voice <= voice_in;
        lat_en    <= gate;
      end
      // Output register loads on the edge entering EMIT, alongside the strobe.
      if (state == ACC2) sample_out <= emit_code(acc_nxt);
    end
  end

  assign sample_valid = (state == EMIT);

endmodule

// File: tb/tb_voice_mixer.sv
// Randomized bench for voice_mixer against a cycle-count / arithmetic reference model.
module tb_voice_mixer;

  localparam int DIV = 48;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] voice0 = 8'h80, voice1 = 8'h80, voice2 = 8'h80;
  logic [2:0] voice_en = 3'b000;
  logic       v3off = 1'b0;
  logic [7:0] sample_out;
  logic       sample_valid;

  int n_chk  = 0;
  int n_fail = 0;

  voice_mixer #(.DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .voice0       (voice0),
    .voice1       (voice1),
    .voice2       (voice2),
    .voice_en     (voice_en),
`ifdef MIXER_V3OFF_EN
    .v3off        (v3off),
`endif
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: expected offset-binary sample from the voices seen at a tick.
  function automatic logic [7:0] ref_sample(input logic [7:0] v0, v1, v2,
                                            input logic [2:0] ven, input logic off);
    int sum, h;
    logic [7:0] v [3];
    v[0] = v0; v[1] = v1; v[2] = v2;
    sum = 0;
    for (int n = 0; n < 3; n++)
      if (ven[n] && !(n == 2 && off)) sum += int'(v[n]) - 128;
    h = sum >>> 1;
    if (h > 127)  h = 127;
    if (h < -128) h = -128;
    return 8'(h + 128);
  endfunction

  typedef struct { int due; logic [7:0] val; } exp_t;
  exp_t       q[$];
  int         strobe_pc[$];
  int         pcnt   = 0;
  int         m_cnt  = 0;
  int         tick_pc = -1;
  logic [7:0] exp_out = 8'h80;

  always @(posedge rst) begin
    q.delete();
    m_cnt   = 0;
    exp_out = 8'h80;
  end

  always @(posedge clk) begin
    logic off;
    pcnt++;
    if (rst) begin
      q.delete();
      m_cnt   = 0;
      exp_out = 8'h80;
    end else if (en) begin
      if (m_cnt == DIV - 1) begin
`ifdef MIXER_V3OFF_EN
        off = v3off;
`else
        off = 1'b0;
`endif
        q.push_back('{due: pcnt + 3,
                      val: ref_sample(voice0, voice1, voice2, voice_en, off)});
        tick_pc = pcnt;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_v;
    if (rst) begin
      chk("rst_valid", sample_valid, 0);
      chk("rst_out", sample_out, 8'h80);
    end else begin
      exp_v = (q.size() > 0) && (q[0].due == pcnt);
      chk("valid", sample_valid, exp_v);
      if (exp_v) exp_out = q.pop_front().val;
      if (sample_valid) strobe_pc.push_back(pcnt);
      chk("out", sample_out, exp_out);
    end
  end

  task automatic wait_strobe(input int n);
    int b = 0;
    while (strobe_pc.size() < n && b < 400) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("strobe_wait", strobe_pc.size() >= n, 1);
  endtask

  task automatic pattern(input string tag, input logic [7:0] a, b, c,
                         input logic [2:0] ven, input logic [7:0] exp);
    voice0 = a; voice1 = b; voice2 = c; voice_en = ven;
    wait_strobe(strobe_pc.size() + 2);
    chk(tag, sample_out, exp);
  endtask

  initial begin
    int rel, base, b;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b1; rel = pcnt;
    voice0 = 8'hFF; voice1 = 8'hFF; voice2 = 8'hFF; voice_en = 3'b111;
    wait_strobe(1);
    if (strobe_pc.size() >= 1) chk("first_strobe", strobe_pc[0] - rel, 51);
    chk("sat_hi", sample_out, 8'hFF);
    wait_strobe(2);
    if (strobe_pc.size() >= 2) chk("gap48", strobe_pc[1] - strobe_pc[0], 48);

    en = 1'b0;
    repeat (10) @(posedge clk);
    #1 en = 1'b1;
    wait_strobe(3);
    if (strobe_pc.size() >= 3) chk("gap58", strobe_pc[2] - strobe_pc[1], 58);

    pattern("sat_lo",  8'h00, 8'h00, 8'h00, 3'b111, 8'h00);
    pattern("v0_only", 8'hC0, 8'h00, 8'hFF, 3'b001, 8'hA0);
    pattern("v2_only", 8'h12, 8'h34, 8'hFF, 3'b100, 8'hBF);
    pattern("mute",    8'hFF, 8'h00, 8'h37, 3'b000, 8'h80);
`ifdef MIXER_V3OFF_EN
    v3off = 1'b1;
    pattern("v3off_1", 8'h12, 8'h34, 8'hFF, 3'b100, 8'h80);
    v3off = 1'b0;
`endif

    // Abort a sample with reset during ACC1.
    voice_en = 3'b111;
    tick_pc = -1;
    b = 0;
    while (tick_pc != pcnt && b < 200) begin @(negedge clk); b++; end
    chk("tick_seen", tick_pc == pcnt, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out", sample_out, 8'h80);
    chk("abort_valid", sample_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0; rel = pcnt; base = strobe_pc.size();
    wait_strobe(base + 1);
    if (strobe_pc.size() > base) chk("rst_cadence", strobe_pc[base] - rel, 51);

    // Randomized phase: inputs change every cycle, en toggles, rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 9))
        0:       begin voice0 = 8'hFF; voice1 = 8'hFF; voice2 = 8'hFF; end
        1:       begin voice0 = 8'h00; voice1 = 8'h00; voice2 = 8'h00; end
        default: begin voice0 = 8'($urandom); voice1 = 8'($urandom); voice2 = 8'($urandom); end
      endcase
      voice_en = 3'($urandom);
      v3off    = 1'($urandom);
      en       = ($urandom_range(0, 7) != 0);
      rst      = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk);
    #1 rst = 1'b0; en = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
